toggle_event_receiver: RTL and testbench

- Receiving end of a two-phase (toggle) request/acknowledge link.
- A sender signals each event by flipping `req_toggle`, with `data_in` held stable. The sender may be the output of another toggling sequential block or a block in another clock domain.
- This block synchronises `req_toggle`, detects each flip and captures `data_in`. It presents the event on a valid/ready interface, counts consumed events, and returns acknowledgment by flipping `ack_toggle`.

---
 rtl/toggle_event_receiver.sv | 109 ++++++++++
 tb/tb_toggle_event_receiver.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_receiver.sv
// Receiving end of a two-phase request/acknowledge link: synchronises the
// request toggle, captures the payload, offers it on valid/ready and acks by toggle.
module toggle_event_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_toggle,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic                   event_valid,
  output logic [DATA_WIDTH-1:0]  event_data,
  input  logic                   event_ready,
  output logic                   ack_toggle,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_level_reg;
  logic                   saved_level_reg, saved_level_next;
  logic                   event_valid_reg, event_valid_next;
  logic [DATA_WIDTH-1:0]  event_data_reg, event_data_next;
  logic                   ack_toggle_reg, ack_toggle_next;
  logic [COUNT_WIDTH-1:0] event_count_reg, event_count_next;
  logic                   overrun_reg, overrun_next;

  logic sync_req;
  logic req_edge;

  assign sync_req = sync_reg[SYNC_STAGES-1];
  // prev_level follows sync_req unconditionally, so a dropped flip never reappears later
  assign req_edge = sync_req ^ prev_level_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      sync_reg        <= '0;
      prev_level_reg  <= 1'b0;
      saved_level_reg <= 1'b0;
      event_valid_reg <= 1'b0;
      event_data_reg  <= '0;
      ack_toggle_reg  <= 1'b0;
      event_count_reg <= '0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sync_reg        <= {sync_reg[SYNC_STAGES-2:0], req_toggle};
      prev_level_reg  <= sync_req;
      saved_level_reg <= saved_level_next;
      event_valid_reg <= event_valid_next;
      event_data_reg  <= event_data_next;
      ack_toggle_reg  <= ack_toggle_next;
      event_count_reg <= event_count_next;
      overrun_reg     <= overrun_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    saved_level_next = saved_level_reg;
    event_valid_next = event_valid_reg;
    event_data_next  = event_data_reg;
    ack_toggle_next  = ack_toggle_reg;
    event_count_next = event_count_reg;
    overrun_next     = overrun_reg;

    case (state_reg)
      IDLE: begin
        if (req_edge) begin
          saved_level_next = sync_req;
          state_next       = CAPTURE;
        end
      end
      CAPTURE: begin
        if (req_edge) overrun_next = 1'b1;
        event_data_next  = data_in;
        event_valid_next = 1'b1;
        state_next       = HOLD;
      end
      HOLD: begin
        if (req_edge) overrun_next = 1'b1;
        if (event_ready) begin
          event_valid_next = 1'b0;
          // ack reflects the level that started this event, not the live request
          ack_toggle_next  = saved_level_reg;
          event_count_next = event_count_reg + COUNT_WIDTH'(1);
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign event_valid = event_valid_reg;
  assign event_data  = event_data_reg;
  assign ack_toggle  = ack_toggle_reg;
  assign event_count = event_count_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Bench for toggle_event_receiver: two instances (2 and 3 sync stages) on shared stimulus,
// checked every cycle against an event-level model plus hand-computed expectations.
module tb_toggle_event_receiver;

  logic       clock;
  logic       reset;
  logic       req_toggle;
  logic [7:0] data_in;
  logic       event_ready;

  logic       d_valid [2];
  logic [7:0] d_data  [2];
  logic       d_ack   [2];
  logic [7:0] d_cnt   [2];
  logic       d_ovr   [2];

  int checks = 0;
  int errors = 0;

  toggle_event_receiver #(.SYNC_STAGES(2), .DATA_WIDTH(8), .COUNT_WIDTH(8)) dut_s2 (
    .clock(clock), .reset(reset), .req_toggle(req_toggle), .data_in(data_in),
    .event_valid(d_valid[0]), .event_data(d_data[0]), .event_ready(event_ready),
    .ack_toggle(d_ack[0]), .event_count(d_cnt[0]), .overrun(d_ovr[0])
  );

  toggle_event_receiver #(.SYNC_STAGES(3), .DATA_WIDTH(8), .COUNT_WIDTH(8)) dut_s3 (
    .clock(clock), .reset(reset), .req_toggle(req_toggle), .data_in(data_in),
    .event_valid(d_valid[1]), .event_data(d_data[1]), .event_ready(event_ready),
    .ack_toggle(d_ack[1]), .event_count(d_cnt[1]), .overrun(d_ovr[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Event-level model: the request as seen through an N-sample delay line; a change
  // starts an event if none is in flight, valid one cycle later, consumed on ready after that.
  logic [3:0] m_hist  [2];
  logic       m_last  [2];
  logic       m_busy  [2];
  logic       m_cap   [2];
  logic       m_saved [2];
  logic       m_valid [2];
  logic [7:0] m_data  [2];
  logic       m_ack   [2];
  logic [7:0] m_cnt   [2];
  logic       m_ovr   [2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_hist[i] <= '0;  m_last[i] <= 1'b0; m_busy[i] <= 1'b0; m_cap[i] <= 1'b0;
        m_saved[i] <= 1'b0; m_valid[i] <= 1'b0; m_data[i] <= '0; m_ack[i] <= 1'b0;
        m_cnt[i] <= '0; m_ovr[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic seen;
        logic chg;
        seen = (i == 0) ? m_hist[i][1] : m_hist[i][2];
        chg  = (seen != m_last[i]);
        m_last[i] <= seen;
        m_hist[i] <= {m_hist[i][2:0], req_toggle};
        if (m_busy[i]) begin
          if (chg) m_ovr[i] <= 1'b1;
          if (!m_cap[i]) begin
            m_cap[i]   <= 1'b1;
            m_valid[i] <= 1'b1;
            m_data[i]  <= data_in;
          end else if (event_ready) begin
            m_valid[i] <= 1'b0;
            m_ack[i]   <= m_saved[i];
            m_cnt[i]   <= m_cnt[i] + 8'd1;
            m_busy[i]  <= 1'b0;
            m_cap[i]   <= 1'b0;
          end
        end else if (chg) begin
          m_busy[i]  <= 1'b1;
          m_cap[i]   <= 1'b0;
          m_saved[i] <= seen;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_valid_s%0d", i + 2), d_valid[i], m_valid[i]);
        if (m_valid[i]) check($sformatf("model_data_s%0d", i + 2), d_data[i], m_data[i]);
        check($sformatf("model_ack_s%0d", i + 2),   d_ack[i],   m_ack[i]);
        check($sformatf("model_count_s%0d", i + 2), d_cnt[i],   m_cnt[i]);
        check($sformatf("model_ovr_s%0d", i + 2),   d_ovr[i],   m_ovr[i]);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    req_toggle = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_valid_s%0d", tag, i + 2), d_valid[i], 0);
      check($sformatf("%s_data_s%0d", tag, i + 2),  d_data[i],  0);
      check($sformatf("%s_ack_s%0d", tag, i + 2),   d_ack[i],   0);
      check($sformatf("%s_count_s%0d", tag, i + 2), d_cnt[i],   0);
      check($sformatf("%s_ovr_s%0d", tag, i + 2),   d_ovr[i],   0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_toggle = 1'b0; data_in = 8'h00; event_ready = 1'b0;

    // Single event, exact latencies for both synchroniser depths
    do_reset();
    check_zero("reset");
    data_in = 8'hA5; event_ready = 1'b1;
    @(negedge clock); req_toggle = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      if (e == 3) check("single_e3_valid_s2", d_valid[0], 0);
      if (e == 4) begin
        check("single_e4_valid_s2", d_valid[0], 1);
        check("single_e4_data_s2",  d_data[0],  8'hA5);
        check("single_e4_valid_s3", d_valid[1], 0);
        check("single_e4_ack_s2",   d_ack[0],   0);
      end
      if (e == 5) begin
        check("single_e5_valid_s2", d_valid[0], 0);
        check("single_e5_ack_s2",   d_ack[0],   1);
        check("single_e5_count_s2", d_cnt[0],   1);
        check("single_e5_valid_s3", d_valid[1], 1);
        check("single_e5_data_s3",  d_data[1],  8'hA5);
      end
      if (e == 6) begin
        check("single_e6_ack_s3",   d_ack[1],   1);
        check("single_e6_count_s3", d_cnt[1],   1);
        check("single_e6_valid_s3", d_valid[1], 0);
        check("single_e6_data_held_s2", d_data[0], 8'hA5);
      end
    end
    $display("single event: ack_s2=%0d ack_s3=%0d count_s2=%0d", d_ack[0], d_ack[1], d_cnt[0]);

    // Backpressure
    do_reset();
    event_ready = 1'b0; data_in = 8'h3C;
    @(negedge clock); req_toggle = 1'b1;
    repeat (20) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_valid_s%0d", i + 2), d_valid[i], 1);
      check($sformatf("bp_data_s%0d", i + 2),  d_data[i],  8'h3C);
      check($sformatf("bp_ack_s%0d", i + 2),   d_ack[i],   0);
      check($sformatf("bp_count_s%0d", i + 2), d_cnt[i],   0);
    end
    event_ready = 1'b1;
    @(negedge clock);
    event_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("bp_done_ack_s%0d", i + 2),   d_ack[i],   1);
      check($sformatf("bp_done_count_s%0d", i + 2), d_cnt[i],   1);
      check($sformatf("bp_done_valid_s%0d", i + 2), d_valid[i], 0);
    end
    $display("backpressure: released after 20 cycles, count_s2=%0d", d_cnt[0]);

    // Handshake stream with counter wrap
    do_reset();
    event_ready = 1'b1;
    for (int n = 0; n < 260; n++) begin
      int t;
      logic [7:0] exp_data;
      exp_data = n[7:0];
      @(negedge clock);
      data_in    = exp_data;
      req_toggle = ~req_toggle;
      t = 0;
      while (t < 40 && !(d_ack[0] == req_toggle && d_ack[1] == req_toggle)) begin
        @(negedge clock);
        t++;
      end
      check("stream_ack_match", {d_ack[0], d_ack[1]}, {req_toggle, req_toggle});
      check("stream_data_s2", d_data[0], exp_data);
      check("stream_data_s3", d_data[1], exp_data);
      $display("stream event %0d: data=%02h count_s2=%0d count_s3=%0d", n, d_data[0], d_cnt[0], d_cnt[1]);
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("stream_count_s%0d", i + 2), d_cnt[i], 4);
      check($sformatf("stream_ovr_s%0d", i + 2),   d_ovr[i], 0);
      check($sformatf("stream_ack_s%0d", i + 2),   d_ack[i], req_toggle);
    end

    // Overrun: second flip while the first event is still held
    do_reset();
    event_ready = 1'b0; data_in = 8'h77;
    @(negedge clock); req_toggle = 1'b1;
    for (int t = 0; t < 20 && !d_valid[0]; t++) @(negedge clock);
    check("ovr_first_valid_s2", d_valid[0], 1);
    req_toggle = 1'b0;
    repeat (10) @(negedge clock);
    check("ovr_flag_s2", d_ovr[0], 1);
    check("ovr_flag_s3", d_ovr[1], 1);
    event_ready = 1'b1;
    @(negedge clock);
    event_ready = 1'b0;
    repeat (20) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("ovr_count_s%0d", i + 2), d_cnt[i],   1);
      check($sformatf("ovr_ack_s%0d", i + 2),   d_ack[i],   1);
      check($sformatf("ovr_valid_s%0d", i + 2), d_valid[i], 0);
      check($sformatf("ovr_sticky_s%0d", i + 2), d_ovr[i],  1);
    end
    $display("overrun: ovr_s2=%0d ovr_s3=%0d count_s2=%0d", d_ovr[0], d_ovr[1], d_cnt[0]);

    // Asynchronous reset while events are held
    do_reset();
    event_ready = 1'b0; data_in = 8'h5A;
    @(negedge clock); req_toggle = 1'b1;
    repeat (8) @(negedge clock);
    check("rst_hold_valid_s2", d_valid[0], 1);
    check("rst_hold_valid_s3", d_valid[1], 1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    req_toggle = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clock);
      check("post_reset_no_valid", {d_valid[0], d_valid[1]}, 2'b00);
    end
    check("post_reset_count_s2", d_cnt[0], 0);
    check("post_reset_count_s3", d_cnt[1], 0);
    $display("reset mid-hold: pending events discarded");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
